// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit state encoding, common to the TX and RX sides.
package uart_pkg;
  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 1302;  // 12.5 MHz sysclk / 9600 baud

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO; the pop data is the combinational head entry, and push/pop take effect on the clock edge.
// Full and empty come from the occupancy count, so pointers can wrap naturally; a push when full or a pop when empty is ignored.
module uart_tx_fifo #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;

  // Storage is left unreset; clearing the pointers and count discards the contents.
  always_ff @(posedge sysclk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: the first start bit begins one cycle after a push into an idle, empty FIFO, and queued frames follow with no idle gap.
// Backpressure: tx_ready is low only while the FIFO is full.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter  int FIFO_DEPTH   = 32,
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      sysclk,
  input  logic                      rst_n,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      uart_rxd_out,
  output logic                      tx_busy,
  output logic [CNT_W-1:0]          fifo_count
);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_tx_state_t            r_state;
  uart_tx_state_t            w_state_nxt;
  logic [BAUD_W-1:0]         r_baud;
  logic [BAUD_W-1:0]         w_baud_nxt;
  logic [2:0]                r_idx;
  logic [2:0]                w_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic                      r_line;
  logic                      w_line_nxt;

  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_baud_end;
  logic [UART_DATA_BITS-1:0] w_head;

  assign w_push       = tx_valid && tx_ready;
  assign w_baud_end   = (r_baud == BAUD_LAST);
  assign tx_ready     = !w_full;
  assign tx_busy      = (r_state != IDLE) || !w_empty;
  assign uart_rxd_out = r_line;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (tx_data),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (fifo_count)
  );

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_line  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_line  <= w_line_nxt;
    end
  end

  // The line is registered, so each state decides the level for the next bit one edge ahead.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_line_nxt  = r_line;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_line_nxt  = 1'b0;
          w_baud_nxt  = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_idx_nxt   = '0;
          w_line_nxt  = r_shift[0];
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_idx == 3'd7) begin
            w_line_nxt  = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_shift_nxt = r_shift >> 1;
            w_line_nxt  = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_line_nxt  = 1'b0;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench: default-rate single frame, fast-rate burst and async reset, and a small-FIFO wrap/hold instance.
module tb_uart_tx_buffered;
  logic sysclk = 1'b0;
  always #40 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  logic       a_rst_n, a_vld, a_rdy, a_line, a_busy;
  logic [7:0] a_dat;
  logic [5:0] a_cnt;
  logic       b_rst_n, b_vld, b_rdy, b_line, b_busy;
  logic [7:0] b_dat;
  logic [5:0] b_cnt;
  logic       c_rst_n, c_vld, c_rdy, c_line, c_busy;
  logic [7:0] c_dat;
  logic [3:0] c_cnt;

  uart_tx_buffered u_a (
    .sysclk(sysclk), .rst_n(a_rst_n), .tx_data(a_dat), .tx_valid(a_vld), .tx_ready(a_rdy),
    .uart_rxd_out(a_line), .tx_busy(a_busy), .fifo_count(a_cnt)
  );
  uart_tx_buffered #(.CLKS_PER_BIT(16), .FIFO_DEPTH(32)) u_b (
    .sysclk(sysclk), .rst_n(b_rst_n), .tx_data(b_dat), .tx_valid(b_vld), .tx_ready(b_rdy),
    .uart_rxd_out(b_line), .tx_busy(b_busy), .fifo_count(b_cnt)
  );
  uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) u_c (
    .sysclk(sysclk), .rst_n(c_rst_n), .tx_data(c_dat), .tx_valid(c_vld), .tx_ready(c_rdy),
    .uart_rxd_out(c_line), .tx_busy(c_busy), .fifo_count(c_cnt)
  );

  int n_chk = 0;
  int n_err = 0;
  int c_acc = 0;
  logic [3:0] c_max = '0;

  always @(posedge sysclk) if (c_vld && c_rdy) c_acc <= c_acc + 1;
  always @(negedge sysclk) if (c_cnt > c_max) c_max <= c_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic line_of(input int sel);
    case (sel)
      0:       return a_line;
      1:       return b_line;
      default: return c_line;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  function automatic logic [7:0] pat(input int p, input int i);
    return 8'(i * 37 + p * 101 + 7);
  endfunction

  // Called on a negedge; samples each bit mid-cell, returns mid-way through the stop bit.
  task automatic rx_byte(input int sel, input int cpb, output logic [7:0] b, output int t_fall);
    int n = 0;
    b = '0;
    t_fall = -1;
    while (line_of(sel) && n < 40000) begin
      @(negedge sysclk);
      n++;
    end
    if (line_of(sel)) begin
      chk("rx_timeout", 32'(line_of(sel)), 0);
      return;
    end
    t_fall = cyc;
    repeat (cpb / 2) @(negedge sysclk);
    chk("rx_start", 32'(line_of(sel)), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge sysclk);
      b[i] = line_of(sel);
    end
    repeat (cpb) @(negedge sysclk);
    chk("rx_stop", 32'(line_of(sel)), 1);
  endtask

  task automatic wait_idle(input int sel);
    int n = 0;
    while (busy_of(sel) && n < 50000) begin
      @(negedge sysclk);
      n++;
    end
    chk($sformatf("idle%0d", sel), 32'(busy_of(sel)), 0);
  endtask

  task automatic push_c(input logic [7:0] d);
    int n = 0;
    c_dat = d;
    c_vld = 1'b1;
    while (!c_rdy && n < 1000) begin
      @(negedge sysclk);
      n++;
    end
    if (!c_rdy) chk("push_timeout", 32'(c_rdy), 1);
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  initial begin
    int off, n, n_low, acc0;
    logic [7:0] a5;
    logic exp_bit;
    a_rst_n = 0; b_rst_n = 0; c_rst_n = 0;
    a_vld = 0; b_vld = 0; c_vld = 0;
    a_dat = '0; b_dat = '0; c_dat = '0;
    repeat (3) @(negedge sysclk);
    chk("rst_line", 32'(a_line), 1);
    chk("rst_ready", 32'(a_rdy), 1);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_count", 32'(a_cnt), 0);
    a_rst_n = 1; b_rst_n = 1; c_rst_n = 1;
    @(negedge sysclk);

    // Single 0xA5 frame at the default divisor
    a_dat = 8'hA5;
    a_vld = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    a_vld = 1'b0;
    chk("a_accept_line", 32'(a_line), 1);
    chk("a_accept_cnt", 32'(a_cnt), 1);
    @(negedge sysclk);
    chk("a_pop_cnt", 32'(a_cnt), 0);
    chk("a_busy_frame", 32'(a_busy), 1);
    off = 0;
    a5 = 8'hA5;
    for (int j = 0; j < 10; j++) begin
      exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : a5[j-1];
      while (off < j * 1302) begin @(negedge sysclk); off++; end
      chk($sformatf("a_bit%0d_first", j), 32'(a_line), 32'(exp_bit));
      while (off < j * 1302 + 1301) begin @(negedge sysclk); off++; end
      chk($sformatf("a_bit%0d_last", j), 32'(a_line), 32'(exp_bit));
    end
    chk("a_busy_last_stop", 32'(a_busy), 1);
    @(negedge sysclk);
    chk("a_busy_done", 32'(a_busy), 0);
    chk("a_line_done", 32'(a_line), 1);

    // Burst of 34 offered bytes into a 32-deep FIFO, 16 clocks per bit
    fork
      begin
        int acc = 0;
        for (int i = 0; i < 34; i++) begin
          b_dat = 8'(i);
          b_vld = 1'b1;
          if (i == 33) chk("burst_rdy34", 32'(b_rdy), 0);
          if (b_rdy) acc++;
          @(posedge sysclk);
          @(negedge sysclk);
        end
        b_vld = 1'b0;
        chk("burst_acc", 32'(acc), 33);
      end
      begin
        logic [7:0] rb;
        int tf, tprev;
        tprev = 0;
        for (int i = 0; i < 33; i++) begin
          rx_byte(1, 16, rb, tf);
          chk($sformatf("burst_byte%0d", i), 32'(rb), 32'(i));
          if (i > 0) chk($sformatf("burst_gap%0d", i), 32'(tf - tprev), 160);
          tprev = tf;
        end
      end
    join
    wait_idle(1);

    // Asynchronous reset during data bit 3 of 0xA5
    b_dat = 8'hA5; b_vld = 1'b1;
    @(posedge sysclk); @(negedge sysclk);
    b_dat = 8'h3C;
    @(posedge sysclk); @(negedge sysclk);
    b_dat = 8'h7E;
    @(posedge sysclk); @(negedge sysclk);
    b_vld = 1'b0;
    repeat (67) @(negedge sysclk);
    chk("rst_pre_line", 32'(b_line), 0);
    chk("rst_pre_cnt", 32'(b_cnt), 2);
    #5 b_rst_n = 1'b0;
    #1;
    chk("rst_async_line", 32'(b_line), 1);
    chk("rst_async_cnt", 32'(b_cnt), 0);
    chk("rst_async_busy", 32'(b_busy), 0);
    chk("rst_async_rdy", 32'(b_rdy), 1);
    repeat (2) @(negedge sysclk);
    b_rst_n = 1'b1;
    n_low = 0;
    repeat (100) begin
      @(negedge sysclk);
      if (!b_line) n_low++;
    end
    chk("rst_stay_high", 32'(n_low), 0);
    chk("rst_after_busy", 32'(b_busy), 0);

    // Fill-and-drain of the 8-deep FIFO, three patterns
    for (int p = 0; p < 3; p++) begin
      fork
        begin
          for (int i = 0; i < 9; i++) push_c(pat(p, i));
          chk($sformatf("wrap%0d_full_cnt", p), 32'(c_cnt), 8);
          chk($sformatf("wrap%0d_full_rdy", p), 32'(c_rdy), 0);
          c_vld = 1'b0;
        end
        begin
          logic [7:0] rb;
          int tf;
          for (int i = 0; i < 9; i++) begin
            rx_byte(2, 4, rb, tf);
            chk($sformatf("wrap%0d_byte%0d", p, i), 32'(rb), 32'(pat(p, i)));
          end
        end
      join
      wait_idle(2);
    end
    chk("wrap_max_count", 32'(c_max), 8);

    // Hold 0x5C on the port while the FIFO is full
    acc0 = c_acc;
    fork
      begin
        for (int i = 0; i < 9; i++) push_c(pat(3, i));
        c_dat = 8'h5C;
        n = 0;
        while (!c_rdy && n < 500) begin
          @(posedge sysclk);
          n++;
          @(negedge sysclk);
        end
        chk("hold_wait", 32'(n), 33);
        @(posedge sysclk);
        @(negedge sysclk);
        c_vld = 1'b0;
        chk("hold_cnt", 32'(c_cnt), 8);
      end
      begin
        logic [7:0] rb;
        int tf;
        for (int i = 0; i < 10; i++) begin
          rx_byte(2, 4, rb, tf);
          chk($sformatf("hold_byte%0d", i), 32'(rb), (i < 9) ? 32'(pat(3, i)) : 32'h5C);
        end
      end
    join
    wait_idle(2);
    chk("hold_acc", 32'(c_acc - acc0), 10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
